// File: rtl/nrisc_pkg.sv
// nrisc_pkg
//   Shared encodings for the NRISC core. The control unit and the
//   PC/return-stack block both import this package, so the PC-select and
//   stack-control codes are defined in one place.
//   No ports: holds only localparams.
package nrisc_pkg;

  // Default PC and stack entry width.
  localparam int NRISC_ADDR_W = 16;

  // Next-PC select codes (PC_ctrl).
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_HOLD = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_RET  = 2'b11;

  // Stack control codes (STACK_ctrl). Code 2'b11 is reserved and acts as a no-op.
  localparam logic [1:0] STK_NOP  = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

endpackage

// File: rtl/nrisc_lifo.sv
// nrisc_lifo
//   Return-address LIFO: storage array, occupancy counter and the derived
//   full/empty flags. A push is ignored when the LIFO is full, and a pop is
//   ignored when it is empty. The caller decides what those cases mean.
//   Ports:
//     clk, rst      clock and synchronous active-high reset (clears the count only)
//     push_i        write wdata_i at the current count, then increment
//     pop_i         decrement the count
//     wdata_i       value to push
//     top_o         newest entry, or 0 when empty (combinational)
//     count_o       number of occupied entries
//     full_o        count_o == DEPTH
//     empty_o       count_o == 0
module nrisc_lifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             top_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             doPush, doPop;

  // While count < DEPTH, the low bits of the count index the next free slot.
  // The slot below that holds the top entry.
  assign wrPtr   = count_q[PTR_W-1:0];
  assign rdPtr   = wrPtr - PTR_W'(1);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign count_o = count_q;
  assign top_o   = empty_o ? '0 : mem_q[rdPtr];

  always_comb begin
    count_d = count_q;
    if (doPush)      count_d = count_q + CNT_W'(1);
    else if (doPop)  count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Storage is not cleared on reset. Stale entries stay hidden because the
  // top is forced to 0 whenever the count is 0.
  always_ff @(posedge clk) begin
    if (!rst && doPush) mem_q[wrPtr] <= wdata_i;
  end

endmodule

// File: rtl/nrisc_pc_stack.sv
// nrisc_pc_stack
//   Program counter and hardware return-address stack for the NRISC core.
//   Ports:
//     clk, rst           clock and synchronous active-high reset
//     PC_en              update strobe; no state changes while it is 0
//     PC_ctrl            next PC: 00 +1, 01 hold, 10 jump address, 11 stack top
//     PC_jump_addr       jump/call target
//     STACK_ctrl         00 nop, 01 push PC+1, 10 pop, 11 nop
//     PC_out             registered fetch address
//     STACK_top          newest return address, 0 when empty
//     STACK_count        occupied entries
//     STACK_full/empty   occupancy flags
//     STACK_overflow     sticky: a push was attempted while full
//     STACK_underflow    sticky: a pop was attempted while empty
module nrisc_pc_stack
  import nrisc_pkg::*;
#(
  parameter int              ADDR_W       = NRISC_ADDR_W,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           PC_en,
  input  logic [1:0]                     PC_ctrl,
  input  logic [ADDR_W-1:0]              PC_jump_addr,
  input  logic [1:0]                     STACK_ctrl,
  output logic [ADDR_W-1:0]              PC_out,
  output logic [ADDR_W-1:0]              STACK_top,
  output logic [$clog2(STACK_DEPTH):0]   STACK_count,
  output logic                           STACK_full,
  output logic                           STACK_empty,
  output logic                           STACK_overflow,
  output logic                           STACK_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d, pcPlusOne;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              pushReq, popReq;

  assign pcPlusOne = pc_q + ADDR_W'(1);
  assign pushReq   = PC_en && (STACK_ctrl == STK_PUSH);
  assign popReq    = PC_en && (STACK_ctrl == STK_POP);

  nrisc_lifo #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .wdata_i (pcPlusOne),
    .top_o   (STACK_top),
    .count_o (STACK_count),
    .full_o  (STACK_full),
    .empty_o (STACK_empty)
  );

  // The return path reads STACK_top before this edge's pop or push lands.
  // This makes RET and push+11 read-before-write.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q || (pushReq && STACK_full);
    unf_d = unf_q || (popReq && STACK_empty);
    if (PC_en) begin
      unique case (PC_ctrl)
        PC_INC:  pc_d = pcPlusOne;
        PC_HOLD: pc_d = pc_q;
        PC_JUMP: pc_d = PC_jump_addr;
        PC_RET:  pc_d = STACK_top;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign PC_out          = pc_q;
  assign STACK_overflow  = ovf_q;
  assign STACK_underflow = unf_q;

endmodule
